time_set_ctrl: RTL and testbench

- Front-panel input stage that sits directly upstream of the alarm-clock core.
- Synchronises and debounces four raw push-buttons (mode, up, down, ok) and lets the user edit a minute value (00-59, BCD).
- Drives the core's minute-digit inputs and its load-time / load-alarm strobes.
- The core samples its load inputs only on its slow 1 s tick, so each load strobe is stretched to a programmable hold length.

---
 rtl/time_set_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Front-panel input stage for the alarm-clock core: button sync/debounce, BCD
// minute editing, and stretched load strobes sized for the core's slow tick.
module time_set_ctrl #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LOAD_HOLD   = 210_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [3:0] m_in1,
    output logic [3:0] m_in0,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic [1:0] edit_mode,
    output logic       busy
);

    localparam int unsigned DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_W    = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam int unsigned NBTN      = 4;
    localparam int unsigned B_MODE    = 0;
    localparam int unsigned B_UP      = 1;
    localparam int unsigned B_DOWN    = 2;
    localparam int unsigned B_OK      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_TIME,
        S_EDIT_ALARM,
        S_LOAD_TIME,
        S_LOAD_ALARM
    } state_e;

    logic [NBTN-1:0]           btn_raw;
    logic [NBTN-1:0]           sync1_d, sync1_q;
    logic [NBTN-1:0]           sync2_d, sync2_q;
    logic [NBTN-1:0][DB_W-1:0] db_cnt_d, db_cnt_q;
    logic [NBTN-1:0]           db_state_d, db_state_q;
    logic [NBTN-1:0]           press_d, press_q;

    logic ev_ok, ev_mode, ev_up, ev_down;

    state_e              state_d, state_q;
    logic [HOLD_W-1:0]   hold_d, hold_q;
    logic                inc, dec;
    logic [3:0]          m_in1_d, m_in1_q;
    logic [3:0]          m_in0_d, m_in0_q;
    logic                ld_time_d, ld_time_q;
    logic                ld_alarm_d, ld_alarm_q;
    logic [1:0]          edit_mode_d, edit_mode_q;
    logic                busy_d, busy_q;

    assign btn_raw = {btn_ok, btn_down, btn_up, btn_mode};

    // Two-flop synchroniser per button
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Debounce: flip only after DB_CYCLES consecutive cycles of disagreement
    always_comb begin
        db_cnt_d   = '0;
        db_state_d = db_state_q;
        press_d    = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_state_d[i] = sync2_q[i];
                    press_d[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Single winner per cycle: ok > mode > up > down; losers are dropped
    always_comb begin
        ev_ok   = press_q[B_OK];
        ev_mode = press_q[B_MODE] & ~press_q[B_OK];
        ev_up   = press_q[B_UP] & ~press_q[B_OK] & ~press_q[B_MODE];
        ev_down = press_q[B_DOWN] & ~press_q[B_OK] & ~press_q[B_MODE] & ~press_q[B_UP];
    end

    // Mode FSM with load-hold counter and registered output decode
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_mode) state_d = S_EDIT_TIME;
            end
            S_EDIT_TIME: begin
                if (ev_ok)        state_d = S_LOAD_TIME;
                else if (ev_mode) state_d = S_EDIT_ALARM;
                else if (ev_up)   inc = 1'b1;
                else if (ev_down) dec = 1'b1;
            end
            S_EDIT_ALARM: begin
                if (ev_ok)        state_d = S_LOAD_ALARM;
                else if (ev_mode) state_d = S_IDLE;
                else if (ev_up)   inc = 1'b1;
                else if (ev_down) dec = 1'b1;
            end
            S_LOAD_TIME, S_LOAD_ALARM: begin
                if (hold_q == HOLD_W'(LOAD_HOLD - 1)) state_d = S_IDLE;
                else                                  hold_d  = hold_q + HOLD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        ld_time_d  = (state_d == S_LOAD_TIME);
        ld_alarm_d = (state_d == S_LOAD_ALARM);
        busy_d     = ld_time_d | ld_alarm_d;
        case (state_d)
            S_EDIT_TIME:  edit_mode_d = 2'd1;
            S_EDIT_ALARM: edit_mode_d = 2'd2;
            S_LOAD_TIME,
            S_LOAD_ALARM: edit_mode_d = 2'd3;
            default:      edit_mode_d = 2'd0;
        endcase
    end

    // BCD minute counter 00..59 with wrap both ways
    always_comb begin
        m_in1_d = m_in1_q;
        m_in0_d = m_in0_q;
        if (inc) begin
            if (m_in0_q >= 4'd9) begin
                m_in0_d = 4'd0;
                m_in1_d = (m_in1_q >= 4'd5) ? 4'd0 : m_in1_q + 4'd1;
            end else begin
                m_in0_d = m_in0_q + 4'd1;
            end
        end else if (dec) begin
            if (m_in0_q == 4'd0 || m_in0_q > 4'd9) begin
                m_in0_d = 4'd9;
                m_in1_d = (m_in1_q == 4'd0 || m_in1_q > 4'd5) ? 4'd5 : m_in1_q - 4'd1;
            end else begin
                m_in0_d = m_in0_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_cnt_q    <= '0;
            db_state_q  <= '0;
            press_q     <= '0;
            state_q     <= S_IDLE;
            hold_q      <= '0;
            m_in1_q     <= '0;
            m_in0_q     <= '0;
            ld_time_q   <= 1'b0;
            ld_alarm_q  <= 1'b0;
            edit_mode_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            db_state_q  <= db_state_d;
            press_q     <= press_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            m_in1_q     <= m_in1_d;
            m_in0_q     <= m_in0_d;
            ld_time_q   <= ld_time_d;
            ld_alarm_q  <= ld_alarm_d;
            edit_mode_q <= edit_mode_d;
            busy_q      <= busy_d;
        end
    end

    assign m_in1     = m_in1_q;
    assign m_in0     = m_in0_q;
    assign ld_time   = ld_time_q;
    assign ld_alarm  = ld_alarm_q;
    assign edit_mode = edit_mode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with small clock/debounce/hold parameters.
module tb_time_set_ctrl;

    localparam int unsigned B_MODE = 0;
    localparam int unsigned B_UP   = 1;
    localparam int unsigned B_DOWN = 2;
    localparam int unsigned B_OK   = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_ok   = 1'b0;
    logic [3:0] m_in1;
    logic [3:0] m_in0;
    logic       ld_time;
    logic       ld_alarm;
    logic [1:0] edit_mode;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(2),
        .LOAD_HOLD  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_ok   (btn_ok),
        .m_in1    (m_in1),
        .m_in0    (m_in0),
        .ld_time  (ld_time),
        .ld_alarm (ld_alarm),
        .edit_mode(edit_mode),
        .busy     (busy)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int unsigned b, input logic v);
        case (b)
            B_MODE:  btn_mode = v;
            B_UP:    btn_up   = v;
            B_DOWN:  btn_down = v;
            default: btn_ok   = v;
        endcase
    endtask

    task automatic press(input int unsigned b);
        set_btn(b, 1'b1);
        tick(6);
        set_btn(b, 1'b0);
        tick(6);
    endtask

    task automatic check_value(input string tag, input int v);
        check_val({tag, "_m1"}, int'(m_in1), v / 10);
        check_val({tag, "_m0"}, int'(m_in0), v % 10);
    endtask

    // Press ok and watch the whole load window cycle by cycle
    task automatic do_load(input bit is_alarm, input int v);
        int nt, na, first, busy_err, val_err, both;
        nt = 0; na = 0; first = -1; busy_err = 0; val_err = 0; both = 0;
        btn_ok = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (ld_time) nt++;
            if (ld_alarm) na++;
            if ((ld_time || ld_alarm) && first < 0) first = c;
            if (ld_time && ld_alarm) both++;
            if (busy != (edit_mode == 2'd3)) busy_err++;
            if (busy != (ld_time | ld_alarm)) busy_err++;
            if (int'(m_in1) != v / 10 || int'(m_in0) != v % 10) val_err++;
        end
        btn_ok = 1'b0;
        tick(8);
        check_val(is_alarm ? "ld_alarm_cycles" : "ld_time_cycles", is_alarm ? na : nt, 10);
        check_val(is_alarm ? "ld_time_quiet" : "ld_alarm_quiet", is_alarm ? nt : na, 0);
        check_val("load_latency", first, 5);
        check_val("load_busy", busy_err, 0);
        check_val("load_value_held", val_err, 0);
        check_val("load_both_high", both, 0);
        check_val("load_end_mode", int'(edit_mode), 0);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        check_val("rst_m1", int'(m_in1), 0);
        check_val("rst_m0", int'(m_in0), 0);
        check_val("rst_ld_time", int'(ld_time), 0);
        check_val("rst_ld_alarm", int'(ld_alarm), 0);
        check_val("rst_mode", int'(edit_mode), 0);
        check_val("rst_busy", int'(busy), 0);

        // Mode press latency: 4 cycles to the pulse, registered one more
        btn_mode = 1'b1;
        tick(4);
        check_val("mode_early", int'(edit_mode), 0);
        tick(1);
        check_val("mode_edit_time", int'(edit_mode), 1);
        check_val("mode_busy", int'(busy), 0);
        check_val("mode_ld_time", int'(ld_time), 0);
        check_val("mode_ld_alarm", int'(ld_alarm), 0);
        check_value("mode_val", 0);
        btn_mode = 1'b0;
        tick(6);

        for (int i = 0; i < 60; i++) begin
            press(B_UP);
            check_value("up_step", (i + 1) % 60);
            check_val("m0_range", int'(m_in0 <= 4'd9), 1);
        end

        press(B_DOWN);
        check_value("down_wrap", 59);
        do_load(1'b0, 59);

        press(B_UP);
        check_value("idle_up_ignored", 59);
        check_val("idle_mode", int'(edit_mode), 0);

        press(B_MODE);
        press(B_MODE);
        check_val("edit_alarm", int'(edit_mode), 2);
        repeat (8) press(B_UP);
        check_value("alarm_set", 7);
        do_load(1'b1, 7);
        check_value("after_alarm", 7);

        press(B_MODE);
        check_val("edit_time_again", int'(edit_mode), 1);
        for (int i = 0; i < 20; i++) begin
            btn_up = ~btn_up;
            tick(1);
        end
        btn_up = 1'b0;
        tick(10);
        check_value("bounce", 7);

        btn_up = 1'b1;
        tick(50);
        btn_up = 1'b0;
        tick(10);
        check_value("hold_once", 8);

        // Same-edge up+ok: ok wins, then reset lands mid-load
        btn_up = 1'b1;
        btn_ok = 1'b1;
        tick(5);
        check_val("tie_ld_time", int'(ld_time), 1);
        check_val("tie_mode", int'(edit_mode), 3);
        check_value("tie_val", 8);
        tick(3);
        check_val("pre_rst_ld_time", int'(ld_time), 1);
        reset = 1'b1;
        #2;
        check_val("midrst_ld_time", int'(ld_time), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_mode", int'(edit_mode), 0);
        check_value("midrst_val", 0);
        btn_up = 1'b0;
        btn_ok = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);
        check_val("post_rst_ld_time", int'(ld_time), 0);
        check_val("post_rst_mode", int'(edit_mode), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
